// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among
// NUM_REQ byte requesters. A grant is held for a whole message (until a byte
// flagged last, or MAX_BURST bytes) so framed messages never interleave.
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int ACK_TO    = 4
) (
  input  logic                      i_clkx16,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [DATA_W-1:0]         o_tx_data,
  output logic                      o_tx_start,
  input  logic                      i_tx_busy,
  output logic                      o_ack_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 8;
  localparam int ACK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gIdx_q, gIdx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ACK_W-1:0]   ackCnt_q, ackCnt_d;
  logic               last_q, last_d;
  logic [DATA_W-1:0]  txData_q, txData_d;
  logic               txStart_q, txStart_d;
  logic               ackErr_q, ackErr_d;

  logic [IDX_W:0]     cand;
  logic [IDX_W-1:0]   pickIdx;
  logic               pickFound;
  logic [IDX_W-1:0]   nextPtr;
  logic [DATA_W-1:0]  grantData;
  logic               grantValid;
  logic               grantLast;

  // Find the first valid requester at or above the pointer, wrapping around;
  // scanning downward lets the smallest offset win without an early exit.
  always_comb begin
    cand      = '0;
    pickIdx   = '0;
    pickFound = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
        cand = cand - (IDX_W + 1)'(NUM_REQ);
      end
      if (i_req_valid[cand[IDX_W-1:0]]) begin
        pickIdx   = cand[IDX_W-1:0];
        pickFound = 1'b1;
      end
    end
  end

  assign nextPtr    = (gIdx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gIdx_q + 1'b1;
  assign grantData  = i_req_data[gIdx_q*DATA_W +: DATA_W];
  assign grantValid = i_req_valid[gIdx_q];
  assign grantLast  = i_req_last[gIdx_q];

  // Next-state logic: grant selection, byte acceptance, ack pacing and release.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gIdx_d    = gIdx_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    ackCnt_d  = ackCnt_q;
    last_d    = last_q;
    txData_d  = txData_q;
    txStart_d = 1'b0;
    ackErr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pickFound) begin
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
          gIdx_d  = pickIdx;
          count_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!grantValid) begin
          grant_d = '0;
          ptr_d   = nextPtr;
          state_d = IDLE;
        end else if (!i_tx_busy) begin
          txData_d  = grantData;
          last_d    = grantLast;
          count_d   = (count_q == CNT_W'(MAX_BURST)) ? count_q : count_q + 1'b1;
          ackCnt_d  = '0;
          txStart_d = 1'b1;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (ackCnt_q == ACK_W'(ACK_TO - 1)) begin
          ackErr_d = 1'b1;
          state_d  = WAIT_DONE;
        end else begin
          ackCnt_d = ackCnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (last_q || (count_q == CNT_W'(MAX_BURST))) begin
            grant_d = '0;
            ptr_d   = nextPtr;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; a byte in flight is simply forgotten.
  always_ff @(posedge i_clkx16) begin
    if (i_rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gIdx_q    <= '0;
      ptr_q     <= '0;
      count_q   <= '0;
      ackCnt_q  <= '0;
      last_q    <= 1'b0;
      txData_q  <= '0;
      txStart_q <= 1'b0;
      ackErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gIdx_q    <= gIdx_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      ackCnt_q  <= ackCnt_d;
      last_q    <= last_d;
      txData_q  <= txData_d;
      txStart_q <= txStart_d;
      ackErr_q  <= ackErr_d;
    end
  end

  assign o_req_ready = ((state_q == SEND) && !i_tx_busy) ? grant_q : '0;
  assign o_grant     = grant_q;
  assign o_tx_data   = txData_q;
  assign o_tx_start  = txStart_q;
  assign o_ack_err   = ackErr_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed tests for the round-robin UART TX scheduler.
// Requesters are modelled as byte queues; a simple transmitter model raises
// busy for BUSY_LEN cycles after each start. Expected starts go into a
// scoreboard queue that a separate monitor pops on every o_tx_start.
module tb_uart_tx_sched;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 16;
  localparam int ACK_TO    = 4;
  localparam int BUSY_LEN  = 10;

  typedef struct packed {
    logic [1:0] req;
    logic [7:0] data;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ*DATA_W-1:0] reqData;
  logic [NUM_REQ-1:0]        reqLast;
  logic [NUM_REQ-1:0]        reqReady;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         txData;
  logic                      txStart;
  logic                      txBusy;
  logic                      ackErr;

  int   checks = 0;
  int   failures = 0;
  logic [8:0] reqQ [NUM_REQ][$];
  exp_t expQ[$];
  exp_t monEntry;
  int   busyCnt = 0;
  bit   noAck = 1'b0;
  int   cycleCnt = 0;
  int   lastStartCycle = 0;
  int   lastErrCycle = 0;
  bit   errPending = 1'b0;
  int   readyCount0 = 0;
  int   errCount = 0;

  uart_tx_sched #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST),
    .ACK_TO   (ACK_TO)
  ) dut (
    .i_clkx16   (clk),
    .i_rst      (rst),
    .i_req_valid(reqValid),
    .i_req_data (reqData),
    .i_req_last (reqLast),
    .o_req_ready(reqReady),
    .o_grant    (grant),
    .o_tx_data  (txData),
    .o_tx_start (txStart),
    .i_tx_busy  (txBusy),
    .o_ack_err  (ackErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Present the head of every requester queue on the request ports.
  task automatic driveReqs();
    for (int n = 0; n < NUM_REQ; n++) begin
      if (reqQ[n].size() > 0) begin
        reqValid[n]                = 1'b1;
        reqData[n*DATA_W +: DATA_W] = reqQ[n][0][7:0];
        reqLast[n]                 = reqQ[n][0][8];
      end else begin
        reqValid[n]                = 1'b0;
        reqData[n*DATA_W +: DATA_W] = '0;
        reqLast[n]                 = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int r, input logic [7:0] d, input logic l);
    reqQ[r].push_back({l, d});
    driveReqs();
  endtask

  task automatic pushExp(input int r, input int d);
    expQ.push_back('{req: 2'(r), data: 8'(d)});
  endtask

  // One clock: observe handshakes mid-cycle, then update requesters and busy.
  task automatic stepCycle();
    logic [NUM_REQ-1:0] fire;
    logic startSeen;
    @(negedge clk);
    fire      = reqValid & reqReady;
    startSeen = txStart;
    @(posedge clk);
    #1;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (fire[n]) void'(reqQ[n].pop_front());
    end
    if (startSeen && !noAck) busyCnt = BUSY_LEN;
    if (busyCnt > 0) begin
      txBusy  = 1'b1;
      busyCnt = busyCnt - 1;
    end else begin
      txBusy = 1'b0;
    end
    driveReqs();
  endtask

  function automatic bit allEmpty();
    bit e = 1'b1;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (reqQ[n].size() > 0) e = 1'b0;
    end
    return e;
  endfunction

  task automatic waitIdle(input string name, input int maxCycles);
    int n = 0;
    while (!(allEmpty() && (grant == '0) && (busyCnt == 0) && (expQ.size() == 0)) &&
           (n < maxCycles)) begin
      stepCycle();
      n++;
    end
    checkOutput({name, "_completes"}, int'(n < maxCycles), 1);
    checkOutput({name, "_grant_idle"}, int'(grant), 0);
  endtask

  // Monitor: scoreboard on every start, ready legality, ack error timing.
  always @(negedge clk) begin
    cycleCnt++;
    if (!rst) begin
      if (reqReady != '0) begin
        checkOutput("ready_onehot_granted",
                    int'($onehot(reqReady) && ((reqReady & ~grant) == '0)), 1);
        if (reqReady[0]) readyCount0++;
      end
      if (txStart) begin
        checkOutput("start_expected", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          monEntry = expQ.pop_front();
          checkOutput("start_data", int'(txData), int'(monEntry.data));
          checkOutput("start_grant", int'(grant), 1 << monEntry.req);
        end
        if (noAck && errPending) begin
          checkOutput("restart_after_err", int'((cycleCnt - lastErrCycle) <= 3), 1);
          errPending = 1'b0;
        end
        lastStartCycle = cycleCnt;
      end
      if (ackErr) begin
        errCount++;
        lastErrCycle = cycleCnt;
        errPending   = 1'b1;
        checkOutput("ack_err_allowed", int'(noAck), 1);
        if (noAck) checkOutput("ack_err_delay", cycleCnt - lastStartCycle, ACK_TO);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    txBusy   = 1'b0;
    reqValid = '1;
    reqData  = '0;
    reqLast  = '0;

    // Reset held with every requester valid: everything stays quiet.
    repeat (2) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rst_ready", int'(reqReady), 0);
      checkOutput("rst_grant", int'(grant), 0);
      checkOutput("rst_tx_data", int'(txData), 0);
      checkOutput("rst_tx_start", int'(txStart), 0);
      checkOutput("rst_ack_err", int'(ackErr), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    driveReqs();

    // Single byte from requester 0.
    readyCount0 = 0;
    pushExp(0, 8'h55);
    applyStimulus(0, 8'h55, 1'b1);
    waitIdle("single", 200);
    checkOutput("single_ready_count", readyCount0, 1);

    // Contention between requesters 1 and 2, one-byte messages (pointer starts at 1).
    pushExp(1, 8'h11); pushExp(2, 8'h21);
    pushExp(1, 8'h12); pushExp(2, 8'h22);
    pushExp(1, 8'h13); pushExp(2, 8'h23);
    applyStimulus(1, 8'h11, 1'b1); applyStimulus(1, 8'h12, 1'b1); applyStimulus(1, 8'h13, 1'b1);
    applyStimulus(2, 8'h21, 1'b1); applyStimulus(2, 8'h22, 1'b1); applyStimulus(2, 8'h23, 1'b1);
    waitIdle("contention", 400);

    // Pointer now at 3: requester 3 beats 0 and 1.
    pushExp(3, 8'h33); pushExp(0, 8'h30); pushExp(1, 8'h31);
    applyStimulus(0, 8'h30, 1'b1);
    applyStimulus(1, 8'h31, 1'b1);
    applyStimulus(3, 8'h33, 1'b1);
    waitIdle("pointer_wrap", 300);

    // Burst lock: requester 0 owns the transmitter for its whole message.
    for (int i = 0; i < 5; i++) begin
      pushExp(0, 8'h40 + i);
      applyStimulus(0, 8'(8'h40 + i), (i == 4));
    end
    pushExp(3, 8'h4F);
    repeat (2) stepCycle();
    applyStimulus(3, 8'h4F, 1'b1);
    waitIdle("burst_lock", 400);

    // MAX_BURST: requester 2 streams 20 bytes without last; requester 1 cuts in.
    for (int i = 0; i < 16; i++) pushExp(2, 8'h60 + i);
    pushExp(1, 8'h7E);
    for (int i = 16; i < 20; i++) pushExp(2, 8'h60 + i);
    for (int i = 0; i < 20; i++) applyStimulus(2, 8'(8'h60 + i), 1'b0);
    repeat (3) stepCycle();
    applyStimulus(1, 8'h7E, 1'b1);
    waitIdle("max_burst", 1000);

    // Ack timeout: transmitter never raises busy.
    noAck    = 1'b1;
    errCount = 0;
    pushExp(0, 8'h81); pushExp(0, 8'h82);
    applyStimulus(0, 8'h81, 1'b0);
    applyStimulus(0, 8'h82, 1'b1);
    waitIdle("ack_timeout", 200);
    checkOutput("ack_err_count", errCount, 2);
    noAck = 1'b0;

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
